contador_modulo_n: RTL
======================

# contador_modulo_n

Parametrised modulo-N up/down counter, the successor to the fixed 0..10 free-running counter. It adds:
- configurable width, modulus and clock prescaler;
- count enable, direction control and synchronous clear;
- a combinational carry for cascading and a registered wrap pulse.

It sits between the clock domain and any block needing a periodic event or a bounded index. Multiple instances chain via `oCarry` → `iEnable`.

## Interface
- `WIDTH`, default 4: counter width in bits.
- `MODULO`, default 11: number of states; count range 0..MODULO-1. Legal range: 2 ≤ MODULO ≤ 2**WIDTH.
- `PRESCALE`, default 1: enabled clocks per count step; must be ≥ 1.
- `PRE_W`, default 4: prescaler register width; must satisfy 2**PRE_W ≥ PRESCALE.
- `iClk`  in  1  single clock, rising edge.
- `iRst_n`  in  1  asynchronous active-low reset.
- `iEnable`  in  1  advances the prescaler while high.
- `iUp`  in  1  1 = count up, 0 = count down.
- `iClear`  in  1  synchronous clear of the count and the prescaler.
- `iLoad`  in  1  synchronous load strobe (only with CONTADOR_CARGA_EN).
- `iValor`  in  WIDTH  load value (only with CONTADOR_CARGA_EN).
- `oCuenta`  out  WIDTH  current count, registered.
- `oCarry`  out  1  combinational; high in a cycle where the next edge wraps the count.
- `oFin`  out  1  registered one-cycle pulse following each wrap.

## Operation
- State is held in registers:
  - count register `rCuenta_Q`;
  - prescaler `rPre_Q` with range 0..PRESCALE-1;
  - wrap flag `rFin_Q`.
- Next-state values are computed combinationally from the registered state only.
- Tick: `tick = iEnable && (rPre_Q == PRESCALE-1)`. When PRESCALE = 1, tick equals `iEnable`.
- Priority per edge, highest first:
  1. `iClear`: count ← 0, prescaler ← 0.
  2. `iLoad`: count ← iValor, prescaler ← 0.
  3. tick: count steps.
  4. `iEnable` alone: prescaler increments.
  5. Otherwise: hold.
- Up step: MODULO-1 → 0 (wrap); otherwise count + 1.
- Down step: 0 → MODULO-1 (wrap); otherwise count − 1.
- Arithmetic is done at WIDTH+1 bits internally; the result never leaves the 0..MODULO-1 range.
- Load value ≥ MODULO is saturated to MODULO-1. Loads never assert `oFin`.
- `oCarry = tick && !iClear && !iLoad && (iUp ? rCuenta_Q == MODULO-1 : rCuenta_Q == 0)`.
- `oFin` ← `oCarry` at each edge, so it is high for exactly one cycle after each wrap.
- A change of `iUp` takes effect on the next tick. The prescaler phase is not disturbed by a direction change.
- Deasserting `iEnable` freezes both the count and the prescaler phase.

## Timing
- Reset (`iRst_n` low): `oCuenta`=0, prescaler=0, `oFin`=0 immediately, without waiting for a clock edge. `oCarry` is 0 whenever count=0 and iUp=1.
- Reset released: counting begins on the first rising edge where `iRst_n`=1.
- Reset mid-count discards the prescaler phase.
- Count update latency: one edge after the tick cycle.
- `oFin` lags `oCarry` by exactly one cycle and coincides with the post-wrap value on `oCuenta`.
- With `iEnable` held high, a wrap occurs every MODULO×PRESCALE cycles.
- Clear and load in the same cycle: clear wins; no `oCarry`/`oFin`.
- Clear coinciding with a wrap: count becomes 0 and no `oFin` is generated.

## Configuration
- `CONTADOR_CARGA_EN` defined:
  - `iLoad` and `iValor` ports exist;
  - load behaves as described under Operation.
- `CONTADOR_CARGA_EN` undefined:
  - both ports are absent;
  - the load branch is removed;
  - the priority order becomes clear > tick > enable > hold.

## Test plan
- Reset: run to count 5, pull `iRst_n` low between edges → `oCuenta`=0 and `oFin`=0 before the next edge; release → count 1 after the first enabled edge.
- Up wrap (defaults): enable for 11 cycles from 0 → sequence 1..10,0. `oCarry` high while count=10; `oFin` high only in the cycle showing 0.
- Down wrap: `iUp`=0 from count 0, one enabled edge → count 10 and `oFin` pulse; next edge → 9.
- Prescale (PRESCALE=3): 6 enabled cycles → count 2. Drop `iEnable` 4 cycles → hold at 2. Re-enable → 3 after 3 more cycles.
- Priority (with CONTADOR_CARGA_EN): `iClear`+`iLoad`(7) together → 0. `iLoad`=7 → 7. `iLoad`=13 → 10; no `oFin` on any load.
- Cascade (MODULO=4): two instances, low instance's `oCarry` drives high instance's `iEnable`; 16 enabled cycles → high instance wraps 3→0 with `oFin` once.

Source files
------------

// File: rtl/contador_modulo_n.sv
// contador_modulo_n
//
// Parametrised modulo-N up/down counter with clock prescaler, count enable,
// direction control and synchronous clear. It replaces the old fixed 0..10
// free-running counter. Instances cascade by wiring oCarry of the lower
// digit to iEnable of the next one.
//
// Optional feature macro: CONTADOR_CARGA_EN
//   defined   -> iLoad / iValor ports exist; a load sits between clear and tick.
//   undefined -> no load ports; priority is clear > tick > enable > hold.
//
// Parameters
//   WIDTH     counter width in bits
//   MODULO    number of states (count range 0..MODULO-1), 2 <= MODULO <= 2**WIDTH
//   PRESCALE  enabled clocks per count step, >= 1
//   PRE_W     prescaler register width, 2**PRE_W >= PRESCALE
//
// Ports
//   iClk      rising-edge clock
//   iRst_n    asynchronous active-low reset
//   iEnable   advances the prescaler while high
//   iUp       1 = count up, 0 = count down
//   iClear    synchronous clear of count and prescaler
//   iLoad     synchronous load strobe         (CONTADOR_CARGA_EN only)
//   iValor    load value, saturated to MODULO-1 (CONTADOR_CARGA_EN only)
//   oCuenta   registered count
//   oCarry    combinational, high when the next edge wraps the count
//   oFin      registered one-cycle pulse following each wrap

module contador_modulo_n #(
  parameter int unsigned WIDTH    = 4,
  parameter int unsigned MODULO   = 11,
  parameter int unsigned PRESCALE = 1,
  parameter int unsigned PRE_W    = 4
) (
  input  logic             iClk,
  input  logic             iRst_n,
  input  logic             iEnable,
  input  logic             iUp,
  input  logic             iClear,
`ifdef CONTADOR_CARGA_EN
  input  logic             iLoad,
  input  logic [WIDTH-1:0] iValor,
`endif
  output logic [WIDTH-1:0] oCuenta,
  output logic             oCarry,
  output logic             oFin
);

  // Elaboration-time parameter sanity.
  if (MODULO < 2 || MODULO > (1 << WIDTH)) begin : gen_bad_modulo
    $error("contador_modulo_n: MODULO out of range for WIDTH");
  end
  if (PRESCALE < 1 || PRESCALE > (1 << PRE_W)) begin : gen_bad_prescale
    $error("contador_modulo_n: PRESCALE out of range for PRE_W");
  end

  // Count limits, held one bit wider than the count so MODULO = 2**WIDTH
  // still compares correctly.
  localparam logic [WIDTH:0]   CuentaMax = (WIDTH+1)'(MODULO - 1);
  localparam logic [WIDTH:0]   CuentaUno = (WIDTH+1)'(1);
  localparam logic [PRE_W-1:0] PreMax    = PRE_W'(PRESCALE - 1);
  localparam logic [PRE_W-1:0] PreUno    = PRE_W'(1);

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [WIDTH-1:0] rCuenta_Q, rCuenta_D;
  logic [PRE_W-1:0] rPre_Q, rPre_D;
  logic             rFin_Q, rFin_D;

  // ---------------------------------------------------------------------------
  // Decode of the registered state
  // ---------------------------------------------------------------------------
  logic             tick;
  logic             enMax;
  logic             enMin;
  logic             carry;
  logic [WIDTH:0]   cuentaExt;
  logic [WIDTH:0]   cuentaPaso;
  logic             unusedMsb;
  logic             cargaActiva;

  assign cuentaExt = {1'b0, rCuenta_Q};
  assign enMax     = (cuentaExt == CuentaMax);
  assign enMin     = (cuentaExt == '0);

  // With PRESCALE = 1, PreMax is 0 and rPre_Q never leaves 0, so tick == iEnable.
  assign tick = iEnable && (rPre_Q == PreMax);

`ifdef CONTADOR_CARGA_EN
  logic [WIDTH:0]   valorExt;
  logic [WIDTH-1:0] valorSat;

  assign cargaActiva = iLoad;
  assign valorExt    = {1'b0, iValor};
  // Out-of-range load values clamp to the top state.
  assign valorSat    = (valorExt > CuentaMax) ? CuentaMax[WIDTH-1:0] : iValor;
`else
  assign cargaActiva = 1'b0;
`endif

  // One count step in the selected direction, wrapping at the modulus.
  always_comb begin
    cuentaPaso = cuentaExt;
    if (iUp) begin
      cuentaPaso = enMax ? '0 : (cuentaExt + CuentaUno);
    end else begin
      cuentaPaso = enMin ? CuentaMax : (cuentaExt - CuentaUno);
    end
  end

  // The wrapped result always fits in WIDTH bits; the extra bit is headroom only.
  assign unusedMsb = cuentaPaso[WIDTH];

  // Carry is suppressed by clear or load since neither produces a wrap.
  always_comb begin
    carry = 1'b0;
    if (tick && !iClear && !cargaActiva) begin
      carry = iUp ? enMax : enMin;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    rCuenta_D = rCuenta_Q;
    rPre_D    = rPre_Q;
    rFin_D    = carry;
    if (iClear) begin
      rCuenta_D = '0;
      rPre_D    = '0;
`ifdef CONTADOR_CARGA_EN
    end else if (iLoad) begin
      rCuenta_D = valorSat;
      rPre_D    = '0;
`endif
    end else if (tick) begin
      rCuenta_D = cuentaPaso[WIDTH-1:0];
      rPre_D    = '0;
    end else if (iEnable) begin
      rPre_D = rPre_Q + PreUno;
    end
  end

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      rCuenta_Q <= '0;
      rPre_Q    <= '0;
      rFin_Q    <= 1'b0;
    end else begin
      rCuenta_Q <= rCuenta_D;
      rPre_Q    <= rPre_D;
      rFin_Q    <= rFin_D;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    oCuenta = rCuenta_Q;
    oCarry  = carry;
    oFin    = rFin_Q;
  end

endmodule
